// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory arbiter: widths, size codes,
// FSM state and owner encodings, and the captured request record.
package mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic [ID_W-1:0] {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } mem_req_t;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store unit onto a
// byte-wide RAM with one-cycle read latency; one FSM sequences the bytes.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_memctrl_req_in,
  input  logic [ADDR_W-1:0] if_memctrl_addr_in,
  output logic              memctrl_if_done_out,
  output logic [31:0]       memctrl_if_inst_out,
  input  logic              lsb_memctrl_req_in,
  input  logic              lsb_memctrl_we_in,
  input  logic [1:0]        lsb_memctrl_size_in,
  input  logic [ADDR_W-1:0] lsb_memctrl_addr_in,
  input  logic [31:0]       lsb_memctrl_data_in,
  output logic              memctrl_lsb_done_out,
  output logic [31:0]       memctrl_lsb_data_out,
  input  logic              rob_memctrl_rst_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full_in
);
  state_t      state;
  owner_t      owner, last_grant;
  mem_req_t    cur, nreq;
  logic [2:0]  idx, nbytes;
  logic [31:0] asm_q, asm_nxt;
  logic        mem_wr_q;
  logic        held_vld;
  logic [7:0]  held_byte, rd_byte, wr_byte;
  logic [4:0]  rd_sh;
  logic [ADDR_W-1:0] wr_addr;
  logic        if_pend, lsb_pend, pick_lsb, stall_grant, stall_wr;

  // A requester whose done is showing is not re-sampled that cycle.
  assign if_pend  = if_memctrl_req_in  & ~memctrl_if_done_out;
  assign lsb_pend = lsb_memctrl_req_in & ~memctrl_lsb_done_out;
  assign pick_lsb = lsb_pend & (~if_pend | (last_grant == OWN_IF));

  always_comb begin
    nreq = '0;
    if (pick_lsb) begin
      nreq.we   = lsb_memctrl_we_in;
      nreq.size = lsb_memctrl_size_in;
      nreq.addr = lsb_memctrl_addr_in;
      nreq.data = lsb_memctrl_data_in;
    end else begin
      nreq.size = SZ_WORD;
      nreq.addr = if_memctrl_addr_in;
    end
  end

  assign nbytes  = byte_count(cur.size);
  assign wr_addr = cur.addr + {{(ADDR_W-3){1'b0}}, idx};
  assign wr_byte = cur.data[{idx[1:0], 3'b000} +: 8];

  assign stall_grant = io_buffer_full_in & (nreq.addr[17:16] == 2'b11);
  assign stall_wr    = io_buffer_full_in & (wr_addr[17:16] == 2'b11);

  // RAM keeps clocking during a freeze, so the byte due at the first frozen
  // edge is parked in held_byte and used when the sequence resumes.
  assign rd_byte = held_vld ? held_byte : mem_din;
  assign rd_sh   = {idx[1:0] - 2'd1, 3'b000};

  always_comb begin
    asm_nxt = asm_q;
    if (idx != 3'd0) asm_nxt[rd_sh +: 8] = rd_byte;
  end

  assign mem_wr = mem_wr_q & rdy_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                <= ST_IDLE;
      owner                <= OWN_IF;
      last_grant           <= OWN_IF;
      cur                  <= '0;
      idx                  <= '0;
      asm_q                <= '0;
      mem_wr_q             <= 1'b0;
      mem_a                <= '0;
      mem_dout             <= '0;
      held_vld             <= 1'b0;
      held_byte            <= '0;
      memctrl_if_done_out  <= 1'b0;
      memctrl_if_inst_out  <= '0;
      memctrl_lsb_done_out <= 1'b0;
      memctrl_lsb_data_out <= '0;
    end else if (!rdy_in) begin
      if (state == ST_READ && !held_vld) begin
        held_vld  <= 1'b1;
        held_byte <= mem_din;
      end
    end else begin
      held_vld             <= 1'b0;
      memctrl_if_done_out  <= 1'b0;
      memctrl_lsb_done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((if_pend | lsb_pend) && !rob_memctrl_rst_in) begin
            cur        <= nreq;
            owner      <= pick_lsb ? OWN_LSB : OWN_IF;
            last_grant <= pick_lsb ? OWN_LSB : OWN_IF;
            idx        <= 3'd0;
            asm_q      <= '0;
            mem_a      <= nreq.addr;
            if (nreq.we) begin
              state <= ST_WRITE;
              if (stall_grant) begin
                mem_wr_q <= 1'b0;
              end else begin
                mem_wr_q <= 1'b1;
                mem_dout <= nreq.data[7:0];
                idx      <= 3'd1;
              end
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rob_memctrl_rst_in) begin
            state <= ST_IDLE;
          end else begin
            idx   <= idx + 3'd1;
            asm_q <= asm_nxt;
            if (idx + 3'd1 < nbytes) mem_a <= cur.addr + {{(ADDR_W-3){1'b0}}, idx + 3'd1};
            if (idx == nbytes) begin
              state <= ST_IDLE;
              if (owner == OWN_LSB) begin
                memctrl_lsb_done_out <= 1'b1;
                memctrl_lsb_data_out <= asm_nxt;
              end else begin
                memctrl_if_done_out <= 1'b1;
                memctrl_if_inst_out <= asm_nxt;
              end
            end
          end
        end
        ST_WRITE: begin
          if (idx == nbytes) begin
            state                <= ST_IDLE;
            mem_wr_q             <= 1'b0;
            memctrl_lsb_done_out <= 1'b1;
          end else if (stall_wr) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_wr_q <= 1'b1;
            mem_a    <= wr_addr;
            mem_dout <= wr_byte;
            idx      <= idx + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model (one-cycle read latency).
module tb_mem_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        lsb_req, lsb_we;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        flush, io_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:262143];
  logic        pl_we;
  logic [17:0] pl_a;
  logic [7:0]  pl_d;

  int checks = 0;
  int errors = 0;
  int if_dn  = 0;
  int lsb_dn = 0;
  int n, base_if, base_lsb;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .if_memctrl_req_in(if_req), .if_memctrl_addr_in(if_addr),
    .memctrl_if_done_out(if_done), .memctrl_if_inst_out(if_inst),
    .lsb_memctrl_req_in(lsb_req), .lsb_memctrl_we_in(lsb_we),
    .lsb_memctrl_size_in(lsb_size), .lsb_memctrl_addr_in(lsb_addr),
    .lsb_memctrl_data_in(lsb_wdata),
    .memctrl_lsb_done_out(lsb_done), .memctrl_lsb_data_out(lsb_rdata),
    .rob_memctrl_rst_in(flush),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full_in(io_full)
  );

  always @(posedge clk_in) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  always @(posedge clk_in) begin
    if (if_done)  if_dn  = if_dn + 1;
    if (lsb_done) lsb_dn = lsb_dn + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    step();
    pl_we = 1'b0;
  endtask

  // Steps until the selected done is seen or the budget runs out.
  task automatic wait_done(input bit lsb, input int max, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(lsb ? lsb_done : if_done) && cyc < max);
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; if_req = 1'b0; if_addr = '0;
    lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = '0; lsb_wdata = '0;
    flush = 1'b0; io_full = 1'b0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    #1;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_ctl", {30'b0, mem_wr, if_done | lsb_done}, 32'h0);
    chk("rst_data", if_inst | lsb_rdata | {24'b0, mem_dout}, 32'h0);

    poke(18'h100, 8'hEE); poke(18'h101, 8'hFF); poke(18'h102, 8'hC0); poke(18'h103, 8'h00);
    poke(18'h104, 8'h78); poke(18'h105, 8'h56); poke(18'h106, 8'h34); poke(18'h107, 8'h12);
    poke(18'h200, 8'h11); poke(18'h201, 8'h22); poke(18'h202, 8'h33); poke(18'h203, 8'h44);
    @(negedge clk_in) rst_n_in = 1'b1;
    step();

    // Fetch word at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fetch_addr", mem_a, 32'h100 + i);
    end
    step(); chk("fetch_early", {31'b0, if_done}, 32'h0);
    step(); chk("fetch_done", {31'b0, if_done}, 32'h1);
    chk("fetch_inst", if_inst, 32'h00C0FFEE);
    if_req = 1'b0;
    step(); chk("fetch_pulse", {31'b0, if_done}, 32'h0);

    // Tie from reset goes to LSB, then IF
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h104;
    if_req = 1'b1; if_addr = 32'h100;
    step(); chk("tie1_lsb", mem_a, 32'h104);
    wait_done(1'b1, 12, n);
    chk("tie1_lat", n, 32'd5);
    chk("tie1_data", lsb_rdata, 32'h12345678);
    chk("tie1_excl", {31'b0, if_done}, 32'h0);
    lsb_req = 1'b0;
    step(); chk("tie1_if", mem_a, 32'h100);
    wait_done(1'b0, 12, n);
    chk("tie1_if_lat", n, 32'd5);
    chk("tie1_if_inst", if_inst, 32'h00C0FFEE);
    if_req = 1'b0;
    step();
    lsb_req = 1'b1; if_req = 1'b1;
    step(); chk("tie2_lsb", mem_a, 32'h104);
    wait_done(1'b1, 12, n);
    lsb_req = 1'b0;
    wait_done(1'b0, 12, n);
    chk("tie2_if_lat", n, 32'd6);
    if_req = 1'b0;
    step();

    // Store half 0xBEEF at 0x200
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h200; lsb_wdata = 32'h1234BEEF;
    step(); chk("sh_b0", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h00, 8'hEF});
    step(); chk("sh_b1", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h01, 8'hBE});
    step(); chk("sh_done", {30'b0, lsb_done, mem_wr}, 32'h2);
    lsb_req = 1'b0;
    step(); chk("sh_ram", {ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]}, 32'h4433BEEF);

    // Byte load, zero-extended
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h201;
    wait_done(1'b1, 10, n);
    chk("lb_lat", n, 32'd3);
    chk("lb_data", lsb_rdata, 32'h000000BE);
    lsb_req = 1'b0;
    step();

    // Store byte to I/O space while UART buffer is full
    base_lsb = lsb_dn;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'hFFFFFFA5;
    io_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("io_stall", {31'b0, mem_wr}, 32'h0);
    end
    io_full = 1'b0;
    step(); chk("io_issue", {mem_wr, 15'b0, mem_a[17:16], mem_a[7:0], mem_dout}, {1'b1, 15'b0, 2'b11, 8'h00, 8'hA5});
    step(); chk("io_done", {31'b0, lsb_done}, 32'h1);
    lsb_req = 1'b0;
    step();
    chk("io_once", lsb_dn - base_lsb, 32'd1);
    chk("io_ram", {24'b0, ram[18'h30000]}, 32'hA5);

    // Flush during fetch; pending LSB granted afterwards
    base_if = if_dn;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    step();
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h104;
    step();
    flush = 1'b1;
    step(); chk("fl_nodone", {31'b0, if_done}, 32'h0);
    flush = 1'b0; if_req = 1'b0;
    step(); chk("fl_lsb_grant", mem_a, 32'h104);
    wait_done(1'b1, 10, n);
    chk("fl_lsb_lat", n, 32'd2);
    chk("fl_lsb_data", lsb_rdata, 32'h00000078);
    chk("fl_if_cnt", if_dn - base_if, 32'd0);
    lsb_req = 1'b0;
    step();

    // Flush during a store does not abort it
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h210; lsb_wdata = 32'hDEADBEEF;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_done(1'b1, 10, n);
    chk("fl_st_lat", n, 32'd2);
    lsb_req = 1'b0;
    step(); chk("fl_st_ram", {ram[18'h213], ram[18'h212], ram[18'h211], ram[18'h210]}, 32'hDEADBEEF);

    // Word load with a two-cycle freeze
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h104;
    step();
    step();
    rdy_in = 1'b0;
    step();
    step(); chk("rdy_hold", mem_a, 32'h105);
    rdy_in = 1'b1;
    wait_done(1'b1, 10, n);
    chk("rdy_lat", n, 32'd4);
    chk("rdy_data", lsb_rdata, 32'h12345678);
    lsb_req = 1'b0;
    step();

    // Reset in the middle of a second load
    base_lsb = lsb_dn;
    lsb_req = 1'b1; lsb_addr = 32'h100;
    step();
    step();
    step();
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_mem_a", mem_a, 32'h0);
    chk("arst_data", if_inst | lsb_rdata | {24'b0, mem_dout}, 32'h0);
    lsb_req = 1'b0;
    @(negedge clk_in) rst_n_in = 1'b1;
    repeat (8) step();
    chk("arst_nodone", lsb_dn - base_lsb, 32'd0);
    chk("arst_out", {lsb_rdata[30:0], lsb_done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Reset is asynchronous and active-low on rst_n_in; all logic is in the single clock domain clk_in.
REQ-002 clk_in  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n_in  input  1  asynchronous active-low reset.
REQ-004 rdy_in  input  1  global enable; low freezes all state.
REQ-005 if_memctrl_req_in  input  1  fetch request, level, held until done; if_memctrl_addr_in  input  32  fetch address.
REQ-006 memctrl_if_done_out  output  1  one-cycle fetch-complete pulse; memctrl_if_inst_out  output  32  fetched word, valid with done.
REQ-007 lsb_memctrl_req_in  input  1  load/store request, level, held until done; lsb_memctrl_we_in  input  1  1 = store.
REQ-008 lsb_memctrl_size_in  input  2  0 = byte, 1 = half, 2 = word (3 treated as word); lsb_memctrl_addr_in  input  32; lsb_memctrl_data_in  input  32  store data, low bytes used.
REQ-009 memctrl_lsb_done_out  output  1  one-cycle pulse; memctrl_lsb_data_out  output  32  load data, zero-extended, valid with done.
REQ-010 rob_memctrl_rst_in  input  1  misprediction flush.
REQ-011 mem_din  input  8  RAM read byte; mem_dout  output  8  RAM write byte; mem_a  output  32  RAM address; mem_wr  output  1  1 = write.
REQ-012 io_buffer_full_in  input  1  UART buffer full.

Function
REQ-013 States: IDLE, READ, WRITE; grant recorded as owner (IF/LSB).
REQ-014 In IDLE, a pending request is granted at the next edge (E); both pending: grant the requester not granted last (round-robin); last-grant resets to IF, so LSB wins the first tie.
REQ-015 Byte count N = 4 for fetch, 1/2/4 for LSB per size; bytes little-endian, address A+i for byte i.
REQ-016 READ: mem_a = A+i driven after edge E+i, i = 0..N-1; RAM has one-cycle latency, byte i captured at edge E+i+2; done pulses high in the cycle after edge E+N+1 with assembled data; state returns to IDLE at the same edge.
REQ-017 WRITE: mem_wr = 1, mem_a = A+i, mem_dout = byte i after edge E+i; done pulses after edge E+N; mem_wr = 0 in IDLE.
REQ-018 I/O stall: when io_buffer_full_in = 1 and A[17:16] = 2'b11, a write byte is not issued (mem_wr = 0, index holds) until it clears.
REQ-019 A requester's req is not re-sampled in the cycle its done is high; the arbiter spends at least one IDLE cycle between transactions.
REQ-020 rob_memctrl_rst_in = 1: any READ (IF or LSB) aborts to IDLE with no done pulse, and requests sampled that cycle are ignored; an in-progress WRITE completes normally.
REQ-021 rdy_in = 0: state, index, outputs hold, except mem_wr forced 0; resumes exactly where left.
REQ-022 Done outputs never high simultaneously; data outputs hold last value between dones.

Reset
REQ-023 On rst_n_in low: state IDLE, index 0, last-grant IF, mem_a 0, mem_dout 0, mem_wr 0, both done outputs 0, both data outputs 0, immediately and independent of clk_in.
REQ-024 Reset mid-transaction discards it; no done is produced after release.

Structure
REQ-025 AddressWidth, IDWidth, size encodings and state encodings live in the shared constant header.
REQ-026 No sub-module; arbitration and byte sequencing are one FSM with an index counter and a 32-bit assembly register.

Verification
REQ-027 Fetch only, A = 0x100, RAM words 0x00C0FFEE -> mem_a 0x100..0x103, if_done after edge E+5, inst 0x00C0FFEE.
REQ-028 IF and LSB both request from reset -> LSB granted first, IF granted immediately after LSB done; next tie goes to LSB.
REQ-029 Store half 0xBEEF to 0x200 -> mem_wr with 0xEF@0x200, 0xBE@0x201, lsb_done after edge E+2; memory word elsewhere untouched.
REQ-030 Store byte to 0x30000 with io_buffer_full_in high 3 cycles -> mem_wr low those cycles, byte issued after release, single done.
REQ-031 Flush during IF read at byte 2 -> no if_done, state IDLE next edge, pending LSB granted following edge; flush during a store -> store completes with done.
REQ-032 rdy_in low 2 cycles mid word load, then rst_n_in pulse mid second load -> first load data correct and timing shifted by 2; after reset all outputs 0 and no done.
